// File: rtl/uart_mult_frame_ctrl_if.sv
// UART-side byte handshake shared by the frame controller and the UART core.
interface uart_mult_frame_ctrl_if;
    logic [7:0] uart_received_data;
    logic       uart_rx_valid;
    logic       uart_tx_ready;
    logic [7:0] uart_transmit_data;
    logic       uart_tx_start;

    modport master (
        output uart_received_data, uart_rx_valid, uart_tx_ready,
        input  uart_transmit_data, uart_tx_start
    );
    modport slave (
        input  uart_received_data, uart_rx_valid, uart_tx_ready,
        output uart_transmit_data, uart_tx_start
    );
endinterface

// File: rtl/uart_mult_frame_ctrl.sv
// Decodes SYNC,A,B frames from the UART, multiplies A*B with a shift-add unit and sends the
// 16-bit product back hi byte first. Define UART_MULT_CHKSUM_EN to append a hi^lo checksum byte.
module uart_mult_frame_ctrl #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_mult_frame_ctrl_if.slave uart,
    output logic [15:0]           product,
    output logic                  product_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic                  timeout_err
);
    typedef enum logic [3:0] {
        IDLE, GET_A, GET_B, MUL, TX_HI, WT_HI, TX_LO, WT_LO
`ifdef UART_MULT_CHKSUM_EN
        , TX_CK, WT_CK
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [23:0] timer;
    logic [7:0]  op_a, mplier;
    logic [15:0] mcand, acc, acc_sum;
    logic [2:0]  bit_cnt;
    logic        wt_low;
    logic        rx, tmo_hit, wt_done, tx_go, in_frame;
    logic [7:0]  tx_byte;

    assign rx       = uart.uart_rx_valid;
    assign tmo_hit  = (timer == TIMEOUT_CYCLES - 24'd1);
    // WT_x only completes once ready has dropped after our own start and come back
    assign wt_done  = wt_low && uart.uart_tx_ready;
    assign in_frame = (state == GET_A) || (state == GET_B);
    assign acc_sum  = acc + (mplier[0] ? mcand : 16'h0000);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_go     = 1'b0;
        tx_byte   = product[15:8];
        case (state)
            IDLE:  if (rx && uart.uart_received_data == SYNC_BYTE) state_nxt = GET_A;
            GET_A: if (rx) state_nxt = GET_B; else if (tmo_hit) state_nxt = IDLE;
            GET_B: if (rx) state_nxt = MUL;   else if (tmo_hit) state_nxt = IDLE;
            MUL:   if (bit_cnt == 3'd7) state_nxt = TX_HI;
            TX_HI: if (uart.uart_tx_ready) begin tx_go = 1'b1; state_nxt = WT_HI; end
            WT_HI: if (wt_done) state_nxt = TX_LO;
            TX_LO: begin
                tx_byte = product[7:0];
                if (uart.uart_tx_ready) begin tx_go = 1'b1; state_nxt = WT_LO; end
            end
`ifdef UART_MULT_CHKSUM_EN
            WT_LO: if (wt_done) state_nxt = TX_CK;
            TX_CK: begin
                tx_byte = product[15:8] ^ product[7:0];
                if (uart.uart_tx_ready) begin tx_go = 1'b1; state_nxt = WT_CK; end
            end
            WT_CK: if (wt_done) state_nxt = IDLE;
`else
            WT_LO: if (wt_done) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer                   <= '0;
            op_a                    <= '0;
            mplier                  <= '0;
            mcand                   <= '0;
            acc                     <= '0;
            bit_cnt                 <= '0;
            wt_low                  <= 1'b0;
            product                 <= '0;
            product_valid           <= 1'b0;
            overrun                 <= 1'b0;
            timeout_err             <= 1'b0;
            uart.uart_transmit_data <= '0;
            uart.uart_tx_start      <= 1'b0;
        end else begin
            product_valid      <= 1'b0;
            timeout_err        <= 1'b0;
            uart.uart_tx_start <= 1'b0;

            if (state == IDLE && rx && uart.uart_received_data == SYNC_BYTE) begin
                overrun <= 1'b0;
                timer   <= '0;
            end
            if (in_frame) begin
                timer <= rx ? 24'd0 : timer + 24'd1;
                if (!rx && tmo_hit) timeout_err <= 1'b1;
            end
            if (state == GET_A && rx) op_a <= uart.uart_received_data;
            if (state == GET_B && rx) begin
                mcand   <= {8'h00, op_a};
                mplier  <= uart.uart_received_data;
                acc     <= '0;
                bit_cnt <= '0;
            end
            if (state == MUL) begin
                acc     <= acc_sum;
                mcand   <= mcand << 1;
                mplier  <= mplier >> 1;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    product       <= acc_sum;
                    product_valid <= 1'b1;
                end
            end
            // Bytes arriving while computing or replying are dropped but flagged
            if (rx && state != IDLE && !in_frame) overrun <= 1'b1;

            if (tx_go) begin
                uart.uart_transmit_data <= tx_byte;
                uart.uart_tx_start      <= 1'b1;
                wt_low                  <= 1'b0;
            end else if (!uart.uart_tx_ready) begin
                wt_low <= 1'b1;
            end
        end
    end
endmodule
